// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard stall controller for the ID stage of an in-order pipeline.
// Detects a load-use dependency, holds IF/ID and injects EX bubbles until the
// pending load data appears on the WB bypass, then selects that data for one
// RESUME cycle. Also drives the EX-result forwarding selects for ALU producers
// and keeps trace counters of stall cycles and load-use events.

module hazard_stall_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        hazard_rs1,
    input  logic        hazard_rs2,
    input  logic        producer_is_load_rs1,
    input  logic        producer_is_load_rs2,
    input  logic        load_done,
    input  logic        flush,
    output logic        stall_if,
    output logic        stall_id,
    output logic        bubble_ex,
    output logic [1:0]  fwd_rs1_sel,
    output logic [1:0]  fwd_rs2_sel,
    output logic [1:0]  state_o,
    output logic [31:0] stall_cycles,
    output logic [15:0] load_use_events
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        LOAD_WAIT = 2'b01,
        RESUME    = 2'b10
    } stateT;

    stateT       r_state;
    stateT       w_nextState;
    logic        r_capRs1;
    logic        r_capRs2;
    logic [31:0] r_stallCycles;
    logic [15:0] r_loadUseEvents;

    logic        w_luRs1;
    logic        w_luRs2;
    logic        w_lu;
    logic        w_enterWait;

    assign w_luRs1     = hazard_rs1 & producer_is_load_rs1;
    assign w_luRs2     = hazard_rs2 & producer_is_load_rs2;
    assign w_lu        = id_valid & (w_luRs1 | w_luRs2);
    assign w_enterWait = (r_state == IDLE) & ~rst & ~flush & w_lu;

    assign state_o         = r_state;
    assign stall_cycles    = r_stallCycles;
    assign load_use_events = r_loadUseEvents;

    // Next-state and output decode; reset and flush force a quiet, no-forward cycle.
    always_comb begin
        w_nextState = r_state;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        bubble_ex   = 1'b0;
        fwd_rs1_sel = 2'b00;
        fwd_rs2_sel = 2'b00;
        if (rst || flush) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (id_valid && hazard_rs1 && !producer_is_load_rs1)
                        fwd_rs1_sel = 2'b01;
                    if (id_valid && hazard_rs2 && !producer_is_load_rs2)
                        fwd_rs2_sel = 2'b01;
                    if (w_lu) begin
                        stall_if    = 1'b1;
                        stall_id    = 1'b1;
                        bubble_ex   = 1'b1;
                        w_nextState = LOAD_WAIT;
                    end
                end
                LOAD_WAIT: begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                    if (load_done)
                        w_nextState = RESUME;
                end
                RESUME: begin
                    fwd_rs1_sel = r_capRs1 ? 2'b10 : 2'b00;
                    fwd_rs2_sel = r_capRs2 ? 2'b10 : 2'b00;
                    w_nextState = IDLE;
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_nextState;
    end

    // Remember which sources wait on the load so RESUME picks load data only for them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_capRs1 <= 1'b0;
            r_capRs2 <= 1'b0;
        end else if (flush) begin
            r_capRs1 <= 1'b0;
            r_capRs2 <= 1'b0;
        end else if (w_enterWait) begin
            r_capRs1 <= w_luRs1;
            r_capRs2 <= w_luRs2;
        end
    end

    // Saturating count of cycles in which IF/ID is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stallCycles <= 32'd0;
        else if (stall_id && (r_stallCycles != 32'hFFFF_FFFF))
            r_stallCycles <= r_stallCycles + 32'd1;
    end

    // Wrapping count of load-use stalls entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_loadUseEvents <= 16'd0;
        else if (w_enterWait)
            r_loadUseEvents <= r_loadUseEvents + 16'd1;
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed testbench for hazard_stall_ctrl. Observed vector layout:
// {stall_if, stall_id, bubble_ex, fwd_rs1_sel, fwd_rs2_sel, state_o}.

module tb_hazard_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic        hazard_rs1;
    logic        hazard_rs2;
    logic        producer_is_load_rs1;
    logic        producer_is_load_rs2;
    logic        load_done;
    logic        flush;
    logic        stall_if;
    logic        stall_id;
    logic        bubble_ex;
    logic [1:0]  fwd_rs1_sel;
    logic [1:0]  fwd_rs2_sel;
    logic [1:0]  state_o;
    logic [31:0] stall_cycles;
    logic [15:0] load_use_events;

    logic [8:0]  obs;
    int          checks;
    int          errors;

    assign obs = {stall_if, stall_id, bubble_ex, fwd_rs1_sel, fwd_rs2_sel, state_o};

    hazard_stall_ctrl dut (
        .clk                  (clk),
        .rst                  (rst),
        .id_valid             (id_valid),
        .hazard_rs1           (hazard_rs1),
        .hazard_rs2           (hazard_rs2),
        .producer_is_load_rs1 (producer_is_load_rs1),
        .producer_is_load_rs2 (producer_is_load_rs2),
        .load_done            (load_done),
        .flush                (flush),
        .stall_if             (stall_if),
        .stall_id             (stall_id),
        .bubble_ex            (bubble_ex),
        .fwd_rs1_sel          (fwd_rs1_sel),
        .fwd_rs2_sel          (fwd_rs2_sel),
        .state_o              (state_o),
        .stall_cycles         (stall_cycles),
        .load_use_events      (load_use_events)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic setInputs(input logic v, input logic h1, input logic l1,
                             input logic h2, input logic l2, input logic ld,
                             input logic fl);
        id_valid             = v;
        hazard_rs1           = h1;
        producer_is_load_rs1 = l1;
        hazard_rs2           = h2;
        producer_is_load_rs2 = l2;
        load_done            = ld;
        flush                = fl;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        setInputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        setInputs(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        checks++;
        if (obs !== 9'b000_00_00_00) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", obs, 9'b000_00_00_00);
        end
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_stall_cycles: got %0d expected 0", stall_cycles);
        end
        checks++;
        if (load_use_events !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_load_use_events: got %0d expected 0", load_use_events);
        end
        setInputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic test_alu_raw;
        setInputs(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs !== 9'b000_01_00_00) begin
            errors++;
            $display("[TB] FAIL alu_raw_rs1: got %b expected %b", obs, 9'b000_01_00_00);
        end
        tick();
        setInputs(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        checks++;
        if (obs !== 9'b000_01_01_00) begin
            errors++;
            $display("[TB] FAIL alu_raw_both_load_done_ignored: got %b expected %b", obs, 9'b000_01_01_00);
        end
        tick();
        setInputs(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs !== 9'b000_00_00_00) begin
            errors++;
            $display("[TB] FAIL alu_raw_invalid_id: got %b expected %b", obs, 9'b000_00_00_00);
        end
        tick();
    endtask

    task automatic test_load_use_rs2;
        logic [8:0] expWait;
        expWait = 9'b111_00_00_01;
        setInputs(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs !== 9'b111_00_00_00) begin
            errors++;
            $display("[TB] FAIL lu_rs2_detect: got %b expected %b", obs, 9'b111_00_00_00);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (i == 3) load_done = 1'b1;
            #1;
            checks++;
            if (obs !== expWait) begin
                errors++;
                $display("[TB] FAIL lu_rs2_wait%0d: got %b expected %b", i, obs, expWait);
            end
        end
        tick();
        load_done = 1'b0;
        #1;
        checks++;
        if (obs !== 9'b000_00_10_10) begin
            errors++;
            $display("[TB] FAIL lu_rs2_resume: got %b expected %b", obs, 9'b000_00_10_10);
        end
        tick();
        setInputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs !== 9'b000_00_00_00) begin
            errors++;
            $display("[TB] FAIL lu_rs2_back_idle: got %b expected %b", obs, 9'b000_00_00_00);
        end
        checks++;
        if (stall_cycles !== 32'd4) begin
            errors++;
            $display("[TB] FAIL lu_rs2_stall_cycles: got %0d expected 4", stall_cycles);
        end
        checks++;
        if (load_use_events !== 16'd1) begin
            errors++;
            $display("[TB] FAIL lu_rs2_events: got %0d expected 1", load_use_events);
        end
        tick();
    endtask

    task automatic test_both_sources;
        setInputs(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs !== 9'b111_00_00_00) begin
            errors++;
            $display("[TB] FAIL both_detect: got %b expected %b", obs, 9'b111_00_00_00);
        end
        tick();
        load_done = 1'b1;
        #1;
        checks++;
        if (obs !== 9'b111_00_00_01) begin
            errors++;
            $display("[TB] FAIL both_wait: got %b expected %b", obs, 9'b111_00_00_01);
        end
        tick();
        setInputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs !== 9'b000_10_10_10) begin
            errors++;
            $display("[TB] FAIL both_resume: got %b expected %b", obs, 9'b000_10_10_10);
        end
        tick();
        checks++;
        if (obs !== 9'b000_00_00_00) begin
            errors++;
            $display("[TB] FAIL both_back_idle: got %b expected %b", obs, 9'b000_00_00_00);
        end
        checks++;
        if (stall_cycles !== 32'd6) begin
            errors++;
            $display("[TB] FAIL both_stall_cycles: got %0d expected 6", stall_cycles);
        end
        checks++;
        if (load_use_events !== 16'd2) begin
            errors++;
            $display("[TB] FAIL both_events: got %0d expected 2", load_use_events);
        end
    endtask

    task automatic test_flush;
        setInputs(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        #1;
        checks++;
        if (obs !== 9'b111_00_00_01) begin
            errors++;
            $display("[TB] FAIL flush_wait1: got %b expected %b", obs, 9'b111_00_00_01);
        end
        checks++;
        if ({dut.r_capRs1, dut.r_capRs2} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL flush_caps_before: got %b expected %b", {dut.r_capRs1, dut.r_capRs2}, 2'b10);
        end
        tick();
        load_done = 1'b1;
        flush     = 1'b1;
        #1;
        checks++;
        if (obs !== 9'b000_00_00_01) begin
            errors++;
            $display("[TB] FAIL flush_wait2_quiet: got %b expected %b", obs, 9'b000_00_00_01);
        end
        tick();
        setInputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs !== 9'b000_00_00_00) begin
            errors++;
            $display("[TB] FAIL flush_idle_no_resume: got %b expected %b", obs, 9'b000_00_00_00);
        end
        checks++;
        if ({dut.r_capRs1, dut.r_capRs2} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL flush_caps_cleared: got %b expected %b", {dut.r_capRs1, dut.r_capRs2}, 2'b00);
        end
        setInputs(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        checks++;
        if (obs !== 9'b000_00_00_00) begin
            errors++;
            $display("[TB] FAIL flush_over_lu: got %b expected %b", obs, 9'b000_00_00_00);
        end
        tick();
        setInputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs !== 9'b000_00_00_00) begin
            errors++;
            $display("[TB] FAIL flush_over_lu_state: got %b expected %b", obs, 9'b000_00_00_00);
        end
        checks++;
        if ({stall_cycles, load_use_events} !== {32'd8, 16'd3}) begin
            errors++;
            $display("[TB] FAIL flush_counters: got %0d/%0d expected 8/3", stall_cycles, load_use_events);
        end
    endtask

    task automatic test_reset_mid_wait;
        setInputs(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 9'b000_00_00_00) begin
            errors++;
            $display("[TB] FAIL rstmid_outputs: got %b expected %b", obs, 9'b000_00_00_00);
        end
        checks++;
        if ({stall_cycles, load_use_events} !== {32'd0, 16'd0}) begin
            errors++;
            $display("[TB] FAIL rstmid_counters: got %0d/%0d expected 0/0", stall_cycles, load_use_events);
        end
        setInputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 rst = 1'b0;
        tick();
        #1;
        checks++;
        if (obs !== 9'b000_00_00_00) begin
            errors++;
            $display("[TB] FAIL rstmid_after_release: got %b expected %b", obs, 9'b000_00_00_00);
        end
        load_done = 1'b0;
        tick();
    endtask

    task automatic test_saturation;
        force dut.r_stallCycles = 32'hFFFF_FFFD;
        #1;
        release dut.r_stallCycles;
        #1;
        setInputs(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        load_done = 1'b1;
        tick();
        setInputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall_cycles !== 32'hFFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL sat_stall_cycles: got %h expected ffffffff", stall_cycles);
        end
        tick();
    endtask

    task automatic test_back_to_back_wrap;
        force dut.r_loadUseEvents = 16'hFFFE;
        #1;
        release dut.r_loadUseEvents;
        #1;
        for (int i = 0; i < 2; i++) begin
            setInputs(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
            flush = 1'b1;
            tick();
            flush = 1'b0;
            #1;
            checks++;
            if (load_use_events !== ((i == 0) ? 16'hFFFF : 16'h0000)) begin
                errors++;
                $display("[TB] FAIL wrap_events%0d: got %h expected %h", i, load_use_events,
                         (i == 0) ? 16'hFFFF : 16'h0000);
            end
        end
        setInputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall_cycles !== 32'hFFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL wrap_stall_still_sat: got %h expected ffffffff", stall_cycles);
        end
        tick();
    endtask

    // Scenario sequence.
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_alu_raw();
        test_load_use_rs2();
        test_both_sources();
        test_flush();
        test_reset_mid_wait();
        test_saturation();
        test_back_to_back_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
